// File: rtl/framebuf_ram.sv
// Frame buffer RAM with a byte-strobed write port and a registered read port.
// A clear engine fills the whole array after reset or on request.
module framebuf_ram #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 6144,
    parameter int                    ADDR_WIDTH  = 13,
    parameter int                    RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    clear_req,
    output logic                    busy,
    output logic                    clear_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_ptrNext;
    logic                    r_clearDone;
    logic                    w_clearDoneNext;
    logic [DATA_WIDTH-1:0]   r_rdData;
    logic                    r_rdValid;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_wrInRange;
    logic                    w_rdInRange;
    logic                    w_wrFire;
    logic                    w_rdFire;
    logic                    w_lastAddr;
    logic [NUM_BYTES-1:0]    w_memByteEn;
    logic [IDX_WIDTH-1:0]    w_memIdx;
    logic [DATA_WIDTH-1:0]   w_memData;
    logic [DATA_WIDTH-1:0]   w_rdWord;

    // Range checks use one extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    assign w_wrInRange = ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign w_rdInRange = ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign w_wrFire    = (r_state == IDLE) && wr_en && w_wrInRange;
    assign w_rdFire    = (r_state == IDLE) && rd_en;
    assign w_lastAddr  = (r_ptr == ADDR_WIDTH'(DEPTH - 1));

    assign busy       = (r_state == CLEAR);
    assign clear_done = r_clearDone;
    assign rd_data    = r_rdData;
    assign rd_valid   = r_rdValid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_ptr       <= '0;
            r_clearDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_ptr       <= w_ptrNext;
            r_clearDone <= w_clearDoneNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_ptrNext       = r_ptr;
        w_clearDoneNext = 1'b0;
        case (r_state)
            CLEAR: begin
                if (w_lastAddr) begin
                    w_stateNext     = IDLE;
                    w_ptrNext       = '0;
                    w_clearDoneNext = 1'b1;
                end else begin
                    w_ptrNext = r_ptr + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                if (clear_req) begin
                    w_stateNext = CLEAR;
                    w_ptrNext   = '0;
                end
            end
            default: begin
                w_stateNext = CLEAR;
                w_ptrNext   = '0;
            end
        endcase
    end

    // The clear engine and the user port share one write path; reset blocks both.
    always_comb begin
        w_memByteEn = '0;
        w_memIdx    = r_ptr[IDX_WIDTH-1:0];
        w_memData   = CLEAR_VALUE;
        if (!reset) begin
            if (r_state == CLEAR) begin
                w_memByteEn = '1;
            end else if (w_wrFire) begin
                w_memByteEn = wr_strb;
                w_memIdx    = wr_addr[IDX_WIDTH-1:0];
                w_memData   = wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_memByteEn[i]) begin
                r_mem[w_memIdx][i*8 +: 8] <= w_memData[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_rdWord = '0;
        if (w_rdInRange) begin
            w_rdWord = r_mem[rd_addr[IDX_WIDTH-1:0]];
            if ((RDW_MODE == 1) && w_wrFire && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (wr_strb[i]) begin
                        w_rdWord[i*8 +: 8] = wr_data[i*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdFire;
            if (w_rdFire) begin
                r_rdData <= w_rdWord;
            end
        end
    end

endmodule
